// File: rtl/xram_ctrl.sv
// Byte-wide initiator for the external 16-bit async SRAM: address/strobe/lane sequencing.
// Optional one-word read buffer enabled by defining XRAM_WORDBUF_EN.
module xram_ctrl #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int RECOV_CYC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [16:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ack,
  output logic        busy,
  output logic [15:0] xa,
  output logic [7:0]  xdo,
  input  logic [15:0] xdi,
  output logic        xoe,
  output logic        xwe,
  output logic        xble,
  output logic        xbhe
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, RECOV
`ifdef XRAM_WORDBUF_EN
    , HIT
`endif
  } state_t;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC);
  localparam logic [3:0] RECOV_LD = 4'(RECOV_CYC);

  state_t      state;
  logic [3:0]  cnt;
  logic        wr_q;
  logic        lane_q;
  logic        accept;
  logic [7:0]  rd_byte;

`ifdef XRAM_WORDBUF_EN
  logic        buf_valid;
  logic [15:0] buf_tag;
  logic [15:0] buf_data;
  logic        tag_match;
  assign tag_match = buf_valid && (buf_tag == addr[16:1]);
`endif

  // The last recovery cycle doubles as an idle slot so back-to-back accepts
  // land every SETUP+PULSE+RECOV cycles.
  assign accept  = req && ((state == IDLE) || ((state == RECOV) && (cnt == 4'd1)));
  assign busy    = (state != IDLE);
  assign rd_byte = lane_q ? xdi[15:8] : xdi[7:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      wr_q   <= 1'b0;
      lane_q <= 1'b0;
      xa     <= 16'd0;
      xdo    <= 8'd0;
      rdata  <= 8'd0;
      ack    <= 1'b0;
      xoe    <= 1'b1;
      xwe    <= 1'b1;
      xble   <= 1'b1;
      xbhe   <= 1'b1;
`ifdef XRAM_WORDBUF_EN
      buf_valid <= 1'b0;
      buf_tag   <= 16'd0;
      buf_data  <= 16'd0;
`endif
    end else begin
      ack <= 1'b0;
      if (accept) begin
        wr_q   <= wr;
        lane_q <= addr[0];
`ifdef XRAM_WORDBUF_EN
        if (wr && tag_match) begin
          if (addr[0]) buf_data[15:8] <= wdata;
          else         buf_data[7:0]  <= wdata;
        end
        if (!wr && tag_match) state <= HIT;
        else
`endif
        begin
          state <= SETUP;
          cnt   <= SETUP_LD;
          xa    <= addr[16:1];
          xdo   <= wdata;
          xble  <= addr[0];
          xbhe  <= !addr[0];
        end
      end else begin
        case (state)
          SETUP: begin
            if (cnt == 4'd1) begin
              state <= STROBE;
              cnt   <= PULSE_LD;
              xoe   <= wr_q;
              xwe   <= !wr_q;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          STROBE: begin
            if (cnt == 4'd1) begin
              xoe  <= 1'b1;
              xwe  <= 1'b1;
              xble <= 1'b1;
              xbhe <= 1'b1;
              ack  <= 1'b1;
              if (!wr_q) begin
                rdata <= rd_byte;
`ifdef XRAM_WORDBUF_EN
                buf_valid <= 1'b1;
                buf_tag   <= xa;
                buf_data  <= xdi;
`endif
              end
              cnt   <= RECOV_LD;
              state <= (RECOV_CYC == 0) ? IDLE : RECOV;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          RECOV: begin
            if (cnt == 4'd1) state <= IDLE;
            else             cnt   <= cnt - 4'd1;
          end
`ifdef XRAM_WORDBUF_EN
          HIT: begin
            state <= IDLE;
            ack   <= 1'b1;
            rdata <= lane_q ? buf_data[15:8] : buf_data[7:0];
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xram_ctrl.sv
// Self-checking bench for xram_ctrl: SRAM responder, byte-level reference memory, directed and random ops.
// Build with XRAM_WORDBUF_EN defined to exercise the read-buffer expectations.
module tb_xram_ctrl;

  localparam int S = 1;
  localparam int P = 2;
`ifdef XRAM_WORDBUF_EN
  localparam bit BUF_ON = 1'b1;
`else
  localparam bit BUF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [16:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ack, busy;
  logic [15:0] xa;
  logic [7:0]  xdo;
  logic [15:0] xdi;
  logic        xoe, xwe, xble, xbhe;

  xram_ctrl #(.SETUP_CYC(S), .PULSE_CYC(P), .RECOV_CYC(1)) dut (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .xa(xa), .xdo(xdo), .xdi(xdi),
    .xoe(xoe), .xwe(xwe), .xble(xble), .xbhe(xbhe)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM responder.
  bit [15:0] sram [0:65535];
  assign xdi = sram[xa];
  always @(posedge clk) begin
    if (xwe === 1'b0) begin
      if (xble === 1'b0) sram[xa][7:0]  <= xdo;
      if (xbhe === 1'b0) sram[xa][15:8] <= xdo;
    end
  end

  // Reference: flat byte-addressed memory plus a predicted buffer word.
  bit [7:0]  ref_mem [0:131071];
  bit        bvalid;
  bit [15:0] btag;

  int total = 0;
  int bad = 0;
  int ack_total = 0;

  always @(negedge clk) if (ack === 1'b1) ack_total++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Presents one request; the next rising edge is expected to be the accept edge E0.
  task automatic txn(input bit w, input logic [16:0] a, input logic [7:0] d, input bit keep);
    int ack_j, s_first, s_cnt, other_low;
    bit hit;
    logic [7:0] rd;
    hit = BUF_ON && !w && bvalid && (btag == a[16:1]);
    req = 1'b1; wr = w; addr = a; wdata = d;
    ack_j = -1; s_first = -1; s_cnt = 0; other_low = 0; rd = 8'h00;
    for (int j = 0; j < 12 && ack_j < 0; j++) begin
      @(posedge clk); #1;
      if (j == 0) begin
        chk("busy_after_accept", busy, 1);
        if (!hit) begin
          chk("xa", xa, a[16:1]);
          chk("xble", xble, a[0]);
          chk("xbhe", xbhe, !a[0]);
          if (w) chk("xdo", xdo, d);
        end
      end
      if ((w ? xwe : xoe) === 1'b0) begin
        if (s_first < 0) s_first = j;
        s_cnt++;
      end
      if ((w ? xoe : xwe) === 1'b0) other_low++;
      if (ack === 1'b1) begin
        ack_j = j;
        rd = rdata;
      end
    end
    if (!keep) req = 1'b0;
    if (w) ref_mem[a] = d;
    if (hit) begin
      chk("hit_ack_cycle", ack_j, 1);
      chk("hit_no_strobe", s_cnt, 0);
    end else begin
      chk("ack_cycle", ack_j, S + P);
      chk("strobe_start", s_first, S);
      chk("strobe_len", s_cnt, P);
    end
    chk("other_strobe_idle", other_low, 0);
    if (!w) begin
      chk("rdata", rd, ref_mem[a]);
      bvalid = 1'b1;
      btag = a[16:1];
    end
  endtask

  initial begin
    int a0, k;
    reset = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    bvalid = 1'b0; btag = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_xoe", xoe, 1);
    chk("rst_xwe", xwe, 1);
    chk("rst_xble", xble, 1);
    chk("rst_xbhe", xbhe, 1);
    chk("rst_xa", xa, 0);
    chk("rst_xdo", xdo, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // High byte write, lane independence.
    txn(1'b1, 17'h00011, 8'hA5, 1'b0);
    txn(1'b1, 17'h00010, 8'h3C, 1'b0);
    txn(1'b0, 17'h00011, 8'h00, 1'b0);
    chk("lane_hi", rdata, 8'hA5);
    txn(1'b0, 17'h00010, 8'h00, 1'b0);
    chk("lane_lo", rdata, 8'h3C);
    @(posedge clk); #1;

    // Back-to-back writes with req held: each txn expects its E0 on the next edge.
    a0 = ack_total;
    txn(1'b1, 17'h00020, 8'h11, 1'b1);
    txn(1'b1, 17'h00021, 8'h22, 1'b1);
    txn(1'b1, 17'h00022, 8'h33, 1'b1);
    txn(1'b1, 17'h00023, 8'h44, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_ack_count", ack_total - a0, 4);

    // Buffer sequence (plain misses without the buffer option).
    txn(1'b0, 17'h00010, 8'h00, 1'b0);
    txn(1'b0, 17'h00011, 8'h00, 1'b0);
    txn(1'b1, 17'h00011, 8'h77, 1'b0);
    txn(1'b0, 17'h00011, 8'h00, 1'b0);
    chk("buf_write_through", rdata, 8'h77);
    @(posedge clk); #1;

    // Reset while xoe is low.
    req = 1'b1; wr = 1'b0; addr = 17'h00022;
    k = 0;
    while (xoe !== 1'b0 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("mid_strobe_reached", k < 10, 1);
    reset = 1'b0; req = 1'b0;
    a0 = ack_total;
    @(posedge clk); #1;
    chk("mid_rst_xoe", xoe, 1);
    chk("mid_rst_busy", busy, 0);
    reset = 1'b1;
    bvalid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_ack", ack_total - a0, 0);

    // Random traffic against the reference memory.
    for (int i = 0; i < 40; i++) begin
      bit        w;
      logic [16:0] a;
      logic [7:0]  d;
      w = 1'($urandom_range(0, 1));
      a = 17'($urandom_range(0, 63));
      if (i % 7 == 3) a = 17'($urandom_range(131000, 131071));
      d = 8'($urandom);
      txn(w, a, d, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
